// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the eight-way round-robin index arbiter.
//   state_t : arbiter FSM state (IDLE, GRANT)
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   idx_t   : requester index type
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : arb_pkg

// File: rtl/rr_arbiter_idx8_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_idx8_if
// Request/grant bundle between the requesters and the arbiter.
//   en        : arbiter enable, low forces no grant
//   req       : request vector, bit i = requester i
//   release_i : one-cycle pulse from the grantee ending its transfer
//   grant_idx : index of the granted requester (decoder select)
//   grant_vld : grant active (decoder enable)
//   timeout   : one-cycle pulse when a grant is revoked by the hold limit
// Modports: master drives requests, slave is the arbiter.
// -----------------------------------------------------------------------------
interface rr_arbiter_idx8_if;
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             release_i;
  idx_t             grant_idx;
  logic             grant_vld;
  logic             timeout;

  modport master (
    output en, req, release_i,
    input  grant_idx, grant_vld, timeout
  );

  modport slave (
    input  en, req, release_i,
    output grant_idx, grant_vld, timeout
  );

endinterface : rr_arbiter_idx8_if

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational find-first-set starting at a rotating pointer.
//   req    : request vector
//   ptr    : highest-priority index for this search
//   winner : first set bit of req at or above ptr, wrapping 7 -> 0
//   any    : at least one request is set (winner is valid)
// -----------------------------------------------------------------------------
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output idx_t             winner,
  output logic             any
);

  // NOTE: every output gets a default before the loop so no path through the
  // block leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // Index arithmetic is IDX_W bits wide, so ptr + i wraps 7 -> 0 for free.
      idx_t cand;
      cand = ptr + idx_t'(i);
      if (!any && req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule : rr_pick8

// File: rtl/rr_arbiter_idx8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_idx8
// Eight-way round-robin arbiter with registered grant index and valid strobe,
// intended to drive a 3-to-8 one-hot decoder. A grant is held until the
// grantee releases it, drops its request, or has held it MAX_HOLD cycles.
// Every grant is followed by at least one cycle with grant_vld low, so the
// decoder never shows two one-hot grants back to back.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/grant bundle (slave side)
// Parameters:
//   MAX_HOLD : cycles a grant may be held before forced rotation, 0 = no limit
//   HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
// -----------------------------------------------------------------------------
module rr_arbiter_idx8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_arbiter_idx8_if.slave    bus
);

  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  // Value of hold_cnt in the last permitted grant cycle (cnt starts at 0).
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);

  state_t            state;
  idx_t              ptr;
  logic [HOLD_W-1:0] hold_cnt;
  idx_t              grant_idx_q;
  logic              grant_vld_q;
  logic              timeout_q;

  idx_t              winner;
  logic              any;
  idx_t              next_ptr;
  logic              grantee_done;

  rr_pick8 u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign next_ptr     = grant_idx_q + idx_t'(1);
  assign grantee_done = bus.release_i || !bus.req[grant_idx_q];

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en && any) begin
            grant_idx_q <= winner;
            grant_vld_q <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end else begin
            grant_vld_q <= 1'b0;
          end
        end

        GRANT: begin
          if (!bus.en) begin
            // Pointer untouched: the interrupted grantee keeps top priority.
            grant_vld_q <= 1'b0;
            state       <= IDLE;
          end else if (grantee_done) begin
            // Checked before the hold limit, so a release in the last
            // permitted cycle suppresses the timeout pulse.
            grant_vld_q <= 1'b0;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
            grant_vld_q <= 1'b0;
            ptr         <= next_ptr;
            timeout_q   <= 1'b1;
            state       <= IDLE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          grant_vld_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant_idx = grant_idx_q;
  assign bus.grant_vld = grant_vld_q;
  assign bus.timeout   = timeout_q;

endmodule : rr_arbiter_idx8

// File: tb/tb_rr_arbiter_idx8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_idx8
// Directed self-checking bench for rr_arbiter_idx8 with MAX_HOLD = 16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_idx8;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter_idx8_if bus ();

  rr_arbiter_idx8 #(
    .MAX_HOLD (16),
    .HOLD_W   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [2:0] idx);
    check({tag, " vld"}, {7'd0, bus.grant_vld}, 8'd1);
    check({tag, " idx"}, {5'd0, bus.grant_idx}, {5'd0, idx});
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " vld"}, {7'd0, bus.grant_vld}, 8'd0);
  endtask

  task automatic pulse_release();
    bus.release_i = 1'b1;
    tick();
    bus.release_i = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.req       = 8'hFF;
    bus.release_i = 1'b0;

    // Reset held with all requests pending.
    tick();
    tick();
    check("rst vld", {7'd0, bus.grant_vld}, 8'd0);
    check("rst idx", {5'd0, bus.grant_idx}, 8'd0);
    check("rst timeout", {7'd0, bus.timeout}, 8'd0);
    rst_n = 1'b1;
    tick();
    expect_grant("post-rst", 3'd0);

    // Full rotation 0 -> 1 -> ... -> 7 -> 0 with one idle cycle between grants.
    for (int k = 1; k <= 8; k++) begin
      pulse_release();
      expect_idle("rot gap");
      tick();
      expect_grant("rot", 3'(k));
    end

    // Wrap and skip from ptr = 0 with req = 1000_0100: 2, 7, 2.
    rst_n = 1'b0;
    #1;
    bus.req = 8'b1000_0100;
    rst_n   = 1'b1;
    tick();
    expect_grant("skip a", 3'd2);
    pulse_release();
    tick();
    expect_grant("skip b", 3'd7);
    pulse_release();
    tick();
    expect_grant("skip c", 3'd2);

    // Drive ptr to 7 via a grant to 6, then only req[0]: wrap grants 0.
    pulse_release();
    bus.req = 8'h40;
    tick();
    expect_grant("to six", 3'd6);
    bus.req = 8'h01;
    pulse_release();
    expect_idle("wrap gap");
    tick();
    expect_grant("wrap 7->0", 3'd0);

    // Drive ptr to 5, then req = 0010_0001 grants 5.
    bus.req = 8'h10;
    tick();
    expect_idle("drop req");
    tick();
    expect_grant("to four", 3'd4);
    pulse_release();
    bus.req = 8'b0010_0001;
    tick();
    expect_grant("ptr5", 3'd5);

    // Hold limit: req[3] alone, no release -> 16 grant cycles, then timeout.
    bus.req = 8'h08;
    tick();
    tick();
    expect_grant("hold start", 3'd3);
    for (int i = 1; i < 16; i++) tick();
    expect_grant("hold cyc16", 3'd3);
    check("hold no early to", {7'd0, bus.timeout}, 8'd0);
    tick();
    expect_idle("hold expire");
    check("timeout pulse", {7'd0, bus.timeout}, 8'd1);
    tick();
    expect_grant("regrant alone", 3'd3);
    check("timeout single", {7'd0, bus.timeout}, 8'd0);

    // Release coinciding with the hold limit: no timeout, rotation to 4.
    bus.req = 8'h18;
    for (int i = 1; i < 16; i++) tick();
    expect_grant("coll last", 3'd3);
    pulse_release();
    expect_idle("coll exit");
    check("coll timeout", {7'd0, bus.timeout}, 8'd0);
    tick();
    expect_grant("coll next", 3'd4);

    // Timeout with two requesters hands over to the next one (3).
    for (int i = 1; i < 16; i++) tick();
    tick();
    check("to2 pulse", {7'd0, bus.timeout}, 8'd1);
    tick();
    expect_grant("to2 next", 3'd3);

    // Enable dropped during grant to 4; 4 keeps priority when restored.
    pulse_release();
    tick();
    expect_grant("en grant", 3'd4);
    bus.en = 1'b0;
    tick();
    expect_idle("en low");
    tick();
    expect_idle("en low hold");
    check("en idx kept", {5'd0, bus.grant_idx}, 8'd4);
    bus.en = 1'b1;
    tick();
    expect_grant("en restore", 3'd4);

    // Asynchronous reset mid-grant; search restarts from 0.
    rst_n = 1'b0;
    #1;
    expect_idle("async rst");
    check("async rst idx", {5'd0, bus.grant_idx}, 8'd0);
    bus.req = 8'b0010_0001;
    #1;
    rst_n = 1'b1;
    tick();
    expect_grant("rst restart", 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rr_arbiter_idx8
